// File: rtl/read_pointer_ctrl.sv
// Read-domain pointer and status controller for the asynchronous FIFO.
// Optional sticky underflow flag is built when READ_POINTER_UNDERFLOW_EN is defined.
module read_pointer_ctrl #(
    parameter int ADDRESS_WIDTH          = 4,
    parameter int SYNC_STAGES            = 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     increment,
    input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
    input  logic                     clear_underflow,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     underflow
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(ALMOST_EMPTY_THRESHOLD);

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wsync_gray;
    logic [PW-1:0] wsync_bin;
    logic [PW-1:0] read_pointer;
    logic [PW-1:0] read_pointer_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] level_next;
    logic          pop;

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Write pointer crosses into this domain through a plain flop chain;
    // gray coding guarantees at most one bit changes per write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= write_pointer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wsync_gray = sync_q[SYNC_STAGES-1];
    assign wsync_bin  = gray_to_bin(wsync_gray);

    // Handshake: a pop is accepted on any rising edge where increment is high
    // and the registered empty flag is low; increment while empty is dropped.
    always_comb begin
        pop               = increment & ~empty;
        read_pointer_next = read_pointer + PW'(pop);
        gray_next         = read_pointer_next ^ (read_pointer_next >> 1);
        level_next        = wsync_bin - read_pointer_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_pointer      <= '0;
            read_pointer_gray <= '0;
            empty             <= 1'b1;
            almost_empty      <= 1'b1;
            level             <= '0;
        end else begin
            read_pointer      <= read_pointer_next;
            read_pointer_gray <= gray_next;
            empty             <= (gray_next == wsync_gray);
            almost_empty      <= (level_next <= AE_LIMIT);
            level             <= level_next;
        end
    end

    assign read_address = read_pointer[ADDRESS_WIDTH-1:0];

`ifdef READ_POINTER_UNDERFLOW_EN
    // Set takes priority over clear so a simultaneous bad pop is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (increment && empty) begin
            underflow <= 1'b1;
        end else if (clear_underflow) begin
            underflow <= 1'b0;
        end
    end
`else
    logic unused_clear_underflow;
    assign unused_clear_underflow = clear_underflow;
    assign underflow              = 1'b0;
`endif

endmodule

// File: doc/read_pointer_ctrl.md
Name: read_pointer_ctrl

Overview:
Read-domain pointer and status controller for the asynchronous FIFO. It is the parametrised successor to the existing 4-bit read-side state block.
- Synchronises the write-domain gray pointer internally through a configurable flop chain.
- Keeps an ADDRESS_WIDTH+1 bit read pointer (extra wrap bit), so all 2**ADDRESS_WIDTH entries are usable.
- Provides registered empty, fill level and almost-empty flags to the read-side consumer and RAM read port.

Parameters:
ADDRESS_WIDTH, 4, RAM address bits; DEPTH = 2**ADDRESS_WIDTH entries.
SYNC_STAGES, 2, flops in the write-pointer synchroniser; legal values >= 2.
ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when level <= this value; legal range 0..DEPTH.

Ports:
clock  input  1  read-domain clock; all state on its rising edge.
reset  input  1  synchronous, active-high reset.
increment  input  1  pop request from consumer.
write_pointer_gray  input  ADDRESS_WIDTH+1  write pointer, gray-coded, asynchronous to clock.
clear_underflow  input  1  clears the sticky underflow flag (optional feature).
read_address  output  ADDRESS_WIDTH  RAM read address = read_pointer[ADDRESS_WIDTH-1:0].
read_pointer_gray  output  ADDRESS_WIDTH+1  registered gray read pointer, sent to the write domain.
empty  output  1  registered empty flag.
almost_empty  output  1  registered, level <= ALMOST_EMPTY_THRESHOLD.
level  output  ADDRESS_WIDTH+1  registered entry count, 0..DEPTH.
underflow  output  1  sticky pop-while-empty flag (optional feature).

Behaviour:
- Reset values, applied synchronously while reset=1:
  - synchroniser stages = 0, read_pointer = 0, read_pointer_gray = 0.
  - empty = 1, almost_empty = 1, level = 0, underflow = 0.
- Synchroniser:
  - write_pointer_gray passes through SYNC_STAGES flops.
  - The last stage (wsync_gray) is decoded gray-to-binary (wsync_bin), full ADDRESS_WIDTH+1 width.
- Pop:
  - pop = increment & !empty, using the registered empty.
  - read_pointer_next = read_pointer + pop, modulo 2**(ADDRESS_WIDTH+1).
  - read_pointer <= read_pointer_next.
  - read_pointer_gray <= next ^ (next >> 1). It is driven straight from a flop, with no combinational gray on the output.
- Empty: empty <= (gray(read_pointer_next) == wsync_gray).
- Level:
  - level <= wsync_bin - read_pointer_next, modulo 2**(ADDRESS_WIDTH+1).
  - Correct for any value 0..DEPTH, across wrap.
  - almost_empty <= (that same next level <= ALMOST_EMPTY_THRESHOLD).
- Latency:
  - A write_pointer_gray change stable before an edge is reflected in empty, level and almost_empty SYNC_STAGES+1 edges later.
  - A pop updates read_address, read_pointer_gray, level and empty on the same edge that accepts it.
- Simultaneous pop and synchronised write-pointer advance on one edge: both apply. level = wsync_bin - read_pointer_next, so there is no net level change for one pop plus one write.
- Pop of the last entry: empty = 1 the next cycle; further increments are ignored and the pointer is unchanged.
- Wrap-around: read_address wraps DEPTH-1 -> 0 and the wrap bit toggles. The full pointer wraps at 2**(ADDRESS_WIDTH+1) with no glitch in empty or level.
- Reset mid-operation: every register returns to its reset value on the next edge, regardless of increment. Pending synchroniser contents are discarded.
- Full detection is not this block's job; level == DEPTH is legal and is reported.

Optional Feature:
Macro READ_POINTER_UNDERFLOW_EN.
- Defined:
  - underflow <= 1 on any edge with increment & empty (and reset = 0).
  - It stays 1 until an edge with clear_underflow = 1 or reset = 1.
  - If set and clear happen on the same edge, set wins.
- Not defined: underflow is tied to 0, clear_underflow is ignored, and no flop is inferred.
- Pop gating is identical in both builds.

Test Plan:
1. Reset, then hold write_pointer_gray = 0 for 10 cycles -> empty = 1, almost_empty = 1, level = 0, read_address = 0, read_pointer_gray = 0, underflow = 0.
2. AW=4, SYNC_STAGES=2: set write_pointer_gray = 5'b00010 (3 entries) at edge N -> empty falls and level = 3 at edge N+3, almost_empty = 0. Pop 2 -> level = 1, almost_empty = 1. Pop 1 -> empty = 1, level = 0.
3. Set write_pointer_gray = 5'b11000 (bin 16) -> after sync latency level = 16. Pop 16 consecutive cycles -> read_address walks 0..15 then 0; read_pointer_gray ends 5'b11000; empty = 1.
4. Run 40 write/pop pairs, advancing the write pointer gray one step per pop -> pointer passes 31 -> 0; level never exceeds 2; empty is never set while level > 0.
5. With macro defined, increment = 1 while empty -> pointer unchanged, underflow = 1 next cycle and held. clear_underflow pulse -> underflow = 0. Without macro, underflow = 0 throughout.
6. Assert reset mid-stream with level = 5 and increment = 1 -> next edge gives empty = 1, level = 0, read_pointer_gray = 0. After reset release, empty stays 1 until a new write pointer has propagated through SYNC_STAGES+1 edges.
